// File: rtl/fpu_unit.sv
// Single-precision IEEE-754 adder/subtractor with a combinational result,
// a registered copy of that result and sticky overflow/underflow flags.
module fpu_unit #(
  parameter int NUM_OP = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_add_sub,
  input  logic [31:0] i_32_a,
  input  logic [31:0] i_32_b,
  output logic [31:0] o_32_s,
  output logic        o_ov_flag,
  output logic        o_un_flag,
  output logic [31:0] o_32_s_q,
  output logic        o_ov_sticky,
  output logic        o_un_sticky
);

  logic              op_sub;
  logic              sa, sb;
  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb;
  logic              a_nan, b_nan, a_inf, b_inf, nan_res;
  logic              sl, ss;
  logic [7:0]        el, es, d;
  logic [23:0]       ml, ms;
  logic [49:0]       sh_ext;
  logic [26:0]       ms_al;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic [26:0]       nm;
  logic signed [9:0] ne, ef;
  logic              rnd;
  logic [24:0]       mr;
  logic [22:0]       frac;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  assign op_sub = (NUM_OP == 1) ? i_add_sub : 1'b0;

  // Subtraction is addition of B with its sign flipped; subnormals collapse to signed zero.
  assign sa = i_32_a[31];
  assign sb = i_32_b[31] ^ op_sub;
  assign ea = i_32_a[30:23];
  assign eb = i_32_b[30:23];
  assign ma = (ea == '0) ? '0 : {1'b1, i_32_a[22:0]};
  assign mb = (eb == '0) ? '0 : {1'b1, i_32_b[22:0]};

  assign a_nan   = (ea == '1) && (i_32_a[22:0] != '0);
  assign b_nan   = (eb == '1) && (i_32_b[22:0] != '0);
  assign a_inf   = (ea == '1) && (i_32_a[22:0] == '0);
  assign b_inf   = (eb == '1) && (i_32_b[22:0] == '0);
  assign nan_res = a_nan || b_nan || (a_inf && b_inf && (sa != sb));

  always_comb begin
    sl = sa; el = ea; ml = ma;
    ss = sb; es = eb; ms = mb;
    if ({eb, mb} > {ea, ma}) begin
      sl = sb; el = eb; ml = mb;
      ss = sa; es = ea; ms = ma;
    end
  end

  // Alignment keeps guard/round in the top 26 bits and folds the rest into sticky.
  always_comb begin
    d      = el - es;
    sh_ext = {ms, 26'b0} >> d;
    if (d >= 8'd26) ms_al = {26'b0, |ms};
    else            ms_al = {sh_ext[49:24], |sh_ext[23:0]};
    if (sl ^ ss) sum = {1'b0, ml, 3'b000} - {1'b0, ms_al};
    else         sum = {1'b0, ml, 3'b000} + {1'b0, ms_al};
  end

  always_comb begin
    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      nm = {sum[27:2], sum[1] | sum[0]};
      ne = $signed({2'b00, el}) + 10'sd1;
    end else begin
      nm = sum[26:0] << lz;
      ne = $signed({2'b00, el}) - $signed({5'b00000, lz});
    end
  end

  always_comb begin
    rnd  = nm[2] & (nm[1] | nm[0] | nm[3]);
    mr   = {1'b0, nm[26:3]} + {24'b0, rnd};
    ef   = mr[24] ? (ne + 10'sd1) : ne;
    frac = mr[24] ? mr[23:1] : mr[22:0];
  end

  always_comb begin
    o_32_s    = '0;
    o_ov_flag = 1'b0;
    o_un_flag = 1'b0;
    if (nan_res) begin
      o_32_s = 32'h7FC0_0000;
    end else if (a_inf) begin
      o_32_s = {sa, 8'hFF, 23'b0};
    end else if (b_inf) begin
      o_32_s = {sb, 8'hFF, 23'b0};
    end else if (sum == '0) begin
      // Only two zeros of the same sign can sum to exact zero with that sign.
      o_32_s = {sa & sb, 31'b0};
    end else if (ef >= 10'sd255) begin
      o_32_s    = {sl, 8'hFF, 23'b0};
      o_ov_flag = 1'b1;
    end else if (ef <= 10'sd0) begin
      o_32_s    = {sl, 31'b0};
      o_un_flag = 1'b1;
    end else begin
      o_32_s = {sl, ef[7:0], frac};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_32_s_q    <= '0;
      o_ov_sticky <= 1'b0;
      o_un_sticky <= 1'b0;
    end else begin
      o_32_s_q    <= o_32_s;
      o_ov_sticky <= o_ov_sticky | o_ov_flag;
      o_un_sticky <= o_un_sticky | o_un_flag;
    end
  end

endmodule

// File: tb/tb_fpu_unit.sv
// Scoreboard bench for fpu_unit: directed vectors push expected results,
// a negedge monitor pops and checks combinational, registered and sticky outputs.
module tb_fpu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        add_sub;
  logic [31:0] a, b;
  logic [31:0] s, s_q;
  logic        ov, un, ov_st, un_st;

  typedef struct {
    int          idx;
    logic [31:0] s;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vidx  = 0;
  logic [31:0] last_s;

  fpu_unit #(.NUM_OP(1)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_add_sub  (add_sub),
    .i_32_a     (a),
    .i_32_b     (b),
    .o_32_s     (s),
    .o_ov_flag  (ov),
    .o_un_flag  (un),
    .o_32_s_q   (s_q),
    .o_ov_sticky(ov_st),
    .o_un_sticky(un_st)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic op,
                       input logic [31:0] es, input logic eov, input logic eun);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    a       = va;
    b       = vb;
    add_sub = op;
    e.idx = vidx; e.s = es; e.ov = eov; e.un = eun;
    q.push_back(e);
    last_s = es;
    vidx++;
  endtask

  // Monitor: the registered output at this negedge must hold the previous vector's result.
  initial begin
    exp_t        e;
    logic [31:0] prev_s = '0;
    logic        prev_valid = 1'b0;
    logic        ov_m = 1'b0, un_m = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        ov_m = 1'b0;
        un_m = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("v%0d_sum", e.idx), s, e.s);
        check($sformatf("v%0d_ov", e.idx), {31'b0, ov}, {31'b0, e.ov});
        check($sformatf("v%0d_un", e.idx), {31'b0, un}, {31'b0, e.un});
        check($sformatf("v%0d_ov_sticky", e.idx), {31'b0, ov_st}, {31'b0, ov_m});
        check($sformatf("v%0d_un_sticky", e.idx), {31'b0, un_st}, {31'b0, un_m});
        if (prev_valid) check($sformatf("v%0d_sum_q", e.idx), s_q, prev_s);
        prev_s     = e.s;
        prev_valid = 1'b1;
        ov_m       = ov_m | e.ov;
        un_m       = un_m | e.un;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; add_sub = 1'b0; a = '0; b = '0; last_s = '0;
    #2;
    check("rst_sum_q", s_q, 32'h0);
    check("rst_ov_sticky", {31'b0, ov_st}, 32'h0);
    check("rst_un_sticky", {31'b0, un_st}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // signed zeros
    apply(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    apply(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    apply(32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    apply(32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    apply(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    apply(32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    apply(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    // infinities and NaN
    apply(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b0, 1'b0);
    apply(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0);
    apply(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0);
    apply(32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, 1'b0, 1'b0);
    apply(32'hFF80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b0, 1'b0);
    apply(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 1'b0, 1'b0);
    apply(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b0, 1'b0);
    apply(32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0);
    apply(32'h3F80_0000, 32'h7F80_0001, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0);
    // normal values, order and sign symmetry
    apply(32'h40B0_0000, 32'h400C_CCCD, 1'b0, 32'h40F6_6666, 1'b0, 1'b0);
    apply(32'h40B0_0000, 32'h400C_CCCD, 1'b1, 32'h4053_3333, 1'b0, 1'b0);
    apply(32'h400C_CCCD, 32'h40B0_0000, 1'b1, 32'hC053_3333, 1'b0, 1'b0);
    apply(32'hC0B0_0000, 32'h400C_CCCD, 1'b0, 32'hC053_3333, 1'b0, 1'b0);
    apply(32'h40B0_0000, 32'hC00C_CCCD, 1'b1, 32'h40F6_6666, 1'b0, 1'b0);
    apply(32'h400C_CCCD, 32'h40B0_0000, 1'b0, 32'h40F6_6666, 1'b0, 1'b0);
    apply(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    apply(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    // rounding, alignment limits, subnormal-as-zero
    apply(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    apply(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 1'b0, 1'b0);
    apply(32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F7F_FFFF, 1'b0, 1'b0);
    apply(32'h3F80_0000, 32'h2F80_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    apply(32'h3F80_0000, 32'h0040_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    apply(32'h7F7F_FFFF, 32'h7280_0000, 1'b0, 32'h7F7F_FFFF, 1'b0, 1'b0);
    // overflow and underflow
    apply(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    apply(32'h7F7F_FFFF, 32'h7300_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    apply(32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'hFF80_0000, 1'b1, 1'b0);
    apply(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    apply(32'h40B0_0000, 32'h400C_CCCD, 1'b1, 32'h4053_3333, 1'b0, 1'b0);
    apply(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);

    // mid-cycle reset: registered state clears at once, combinational path untouched
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_sum_q", s_q, 32'h0);
    check("midrst_ov_sticky", {31'b0, ov_st}, 32'h0);
    check("midrst_un_sticky", {31'b0, un_st}, 32'h0);
    check("midrst_comb_sum", s, last_s);
    @(posedge clk);
    #1;
    check("rsthold_sum_q", s_q, 32'h0);

    apply(32'h40B0_0000, 32'h400C_CCCD, 1'b0, 32'h40F6_6666, 1'b0, 1'b0);
    apply(32'hC0B0_0000, 32'h400C_CCCD, 1'b0, 32'hC053_3333, 1'b0, 1'b0);
    apply(32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F7F_FFFF, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
